countdown_scheduler: RTL and testbench



---
 rtl/timer_pkg.sv | 6 +
 rtl/rr_arbiter.sv | 32 +++
 rtl/countdown_scheduler.sv | 68 ++++++
 tb/tb_countdown_scheduler.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// timer_pkg: shared timebase defaults and countdown channel state encoding.
package timer_pkg;
  localparam int DEF_CLK_HZ = 100000000;
  localparam int DEF_SEC_W = 12;
  typedef enum logic [1:0] {IDLE, RUN, FIRE} chan_state_e;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin arbiter; ptr is the highest-priority requester and
// moves to the channel after the winner whenever a grant is issued.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  output logic [N-1:0] grant
);
  localparam int PW = $clog2(N);
  logic [PW-1:0] ptr, nxt, idx;
  int j;
  always_comb begin
    grant = '0;
    nxt = ptr;
    idx = '0;
    j = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j -= N;
      idx = PW'(j);
      if (grant == '0 && req[idx]) begin
        grant[idx] = 1'b1;
        nxt = (j == N - 1) ? '0 : PW'(j + 1);
      end
    end
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) ptr <= '0;
    else if (|grant) ptr <= nxt;
endmodule

// File: rtl/countdown_scheduler.sv
// countdown_scheduler: N_CH second-resolution countdown timers sharing one
// prescaled 1 Hz enable strobe and one round-robin arbitrated load port.
module countdown_scheduler
  import timer_pkg::*;
#(
  parameter int CLK_HZ = DEF_CLK_HZ,
  parameter int N_CH   = 4,
  parameter int SEC_W  = DEF_SEC_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_CH-1:0]         req,
  input  logic [N_CH*SEC_W-1:0]   req_secs,
  input  logic [N_CH-1:0]         cancel,
  output logic [N_CH-1:0]         grant,
  output logic [N_CH-1:0]         busy,
  output logic [N_CH-1:0]         done,
  input  logic [$clog2(N_CH)-1:0] sel,
  output logic [SEC_W-1:0]        remaining,
  output logic                    sec_tick
);
  localparam int PS_W = $clog2(CLK_HZ);
  localparam int SEL_W = $clog2(N_CH);
  localparam logic [PS_W-1:0] PS_TOP = PS_W'(CLK_HZ - 1);
  logic [PS_W-1:0] ps;
  logic [SEC_W-1:0] counts [N_CH];
  rr_arbiter #(.N(N_CH)) u_arb (
    .clk   (clk),
    .reset (reset),
    .req   (req & ~cancel),
    .grant (grant)
  );
  // prescaler idles at zero so the first tick lands CLK_HZ cycles after a load
  assign sec_tick = |busy && ps == PS_TOP;
  always_ff @(posedge clk or negedge reset)
    if (!reset) ps <= '0;
    else ps <= (|busy && ps != PS_TOP) ? ps + 1'b1 : '0;
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    chan_state_e state;
    logic [SEC_W-1:0] count;
    logic [SEC_W-1:0] secs;
    assign secs = req_secs[i*SEC_W +: SEC_W];
    always_ff @(posedge clk or negedge reset)
      if (!reset) begin
        state <= IDLE;
        count <= '0;
      end else if (cancel[i] && state == RUN) begin
        state <= IDLE;
        count <= '0;
      end else if (grant[i]) begin
        state <= (secs != '0) ? RUN : FIRE;
        count <= secs;
      end else if (state == RUN && sec_tick) begin
        state <= (count == SEC_W'(1)) ? FIRE : RUN;
        count <= count - 1'b1;
      end else if (state == FIRE) begin
        state <= IDLE;
      end
    assign counts[i] = count;
    assign busy[i] = state == RUN;
    assign done[i] = state == FIRE;
  end
  always_comb begin
    remaining = '0;
    for (int k = 0; k < N_CH; k++)
      if (sel == SEL_W'(k)) remaining = counts[k];
  end
endmodule

// File: tb/tb_countdown_scheduler.sv
// tb_countdown_scheduler: directed checks of load, contention, zero load,
// cancel-vs-tick, reload-on-tick and asynchronous reset, with CLK_HZ=10.
module tb_countdown_scheduler;
  localparam int HZ = 10, N = 4, W = 12;
  logic clk = 1'b0, reset = 1'b0;
  logic [N-1:0] req = '0, cancel = '0;
  logic [N*W-1:0] req_secs = '0;
  logic [1:0] sel = '0;
  logic [N-1:0] grant, busy, done;
  logic [W-1:0] remaining;
  logic sec_tick;
  logic [N-1:0] g;
  logic [N-1:0] order [4] = '{4'b1000, 4'b0001, 4'b0010, 4'b0100};
  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  countdown_scheduler #(.CLK_HZ(HZ), .N_CH(N), .SEC_W(W)) dut (
    .clk(clk), .reset(reset), .req(req), .req_secs(req_secs), .cancel(cancel),
    .grant(grant), .busy(busy), .done(done), .sel(sel),
    .remaining(remaining), .sec_tick(sec_tick)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic set_secs(input int ch, input int v);
    req_secs[ch*W +: W] = W'(v);
  endtask

  initial begin
    repeat (3) step();
    check("rst_grant", 32'(grant), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_tick", 32'(sec_tick), 0);
    check("rst_remaining", 32'(remaining), 0);
    reset = 1'b1;
    step();
    // single load of 3 s on ch0
    set_secs(0, 3);
    req = 4'b0001;
    @(negedge clk);
    check("load_grant", 32'(grant), 1);
    step();
    req = '0;
    for (int c = 1; c <= 31; c++) begin
      @(negedge clk);
      check($sformatf("load_tick c%0d", c), 32'(sec_tick), (c % 10 == 0) ? 1 : 0);
      check($sformatf("load_done c%0d", c), 32'(done), (c == 31) ? 1 : 0);
      check($sformatf("load_busy c%0d", c), 32'(busy), (c <= 30) ? 1 : 0);
      check($sformatf("load_rem c%0d", c), 32'(remaining),
            (c <= 10) ? 3 : (c <= 20) ? 2 : (c <= 30) ? 1 : 0);
      step();
    end
    // zero-second load on ch1 fires without ever running
    set_secs(1, 0);
    req = 4'b0010;
    @(negedge clk);
    check("zero_grant", 32'(grant), 2);
    step();
    req = '0;
    @(negedge clk);
    check("zero_done", 32'(done), 2);
    check("zero_busy", 32'(busy), 0);
    step();
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      check($sformatf("zero_idle_tick c%0d", c), 32'(sec_tick), 0);
      check($sformatf("zero_idle_done c%0d", c), 32'(done), 0);
      check($sformatf("zero_idle_busy c%0d", c), 32'(busy), 0);
      step();
    end
    // ch2 granted last, then all four contend
    set_secs(2, 0);
    req = 4'b0100;
    @(negedge clk);
    check("prep_grant", 32'(grant), 4);
    step();
    req = '0;
    repeat (2) step();
    for (int s = 0; s < 4; s++) set_secs(s, 4 + s);
    req = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("rr_grant %0d", k), 32'(grant), 32'(order[k]));
      step();
      req &= ~order[k];
    end
    @(negedge clk);
    check("rr_busy", 32'(busy), 4'hf);
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s);
      #1;
      check($sformatf("rr_rem ch%0d", s), 32'(remaining), 4 + s);
    end
    sel = '0;
    step();
    // cancel blocks grant and clears all running channels
    req = 4'b1000;
    cancel = 4'b1111;
    @(negedge clk);
    check("cancel_blocks_grant", 32'(grant), 0);
    step();
    cancel = '0;
    req = '0;
    @(negedge clk);
    check("cancel_all_busy", 32'(busy), 0);
    check("cancel_all_done", 32'(done), 0);
    step();
    // cancel on the tick cycle with ch0 count=2
    set_secs(0, 2);
    req = 4'b0001;
    @(negedge clk);
    check("ct_grant", 32'(grant), 1);
    step();
    req = '0;
    repeat (9) step();
    cancel = 4'b0001;
    @(negedge clk);
    check("ct_tick", 32'(sec_tick), 1);
    check("ct_rem_before", 32'(remaining), 2);
    step();
    cancel = '0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      check($sformatf("ct_busy c%0d", c), 32'(busy), 0);
      check($sformatf("ct_done c%0d", c), 32'(done), 0);
      check($sformatf("ct_tick_held c%0d", c), 32'(sec_tick), 0);
      check($sformatf("ct_rem c%0d", c), 32'(remaining), 0);
      step();
    end
    // reload with 5 s on the tick cycle while count=1
    set_secs(0, 1);
    req = 4'b0001;
    @(negedge clk);
    check("rl_grant0", 32'(grant), 1);
    step();
    req = '0;
    repeat (9) step();
    set_secs(0, 5);
    req = 4'b0001;
    @(negedge clk);
    check("rl_grant1", 32'(grant), 1);
    check("rl_tick", 32'(sec_tick), 1);
    check("rl_rem_before", 32'(remaining), 1);
    step();
    req = '0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check($sformatf("rl_done c%0d", c), 32'(done), 0);
      check($sformatf("rl_busy c%0d", c), 32'(busy), 1);
      check($sformatf("rl_rem c%0d", c), 32'(remaining), 5);
      step();
    end
    cancel = 4'b0001;
    step();
    cancel = '0;
    step();
    // three channels running, then an asynchronous reset pulse
    for (int s = 0; s < 3; s++) set_secs(s, 9);
    req = 4'b0111;
    for (int k = 0; k < 10 && req != '0; k++) begin
      @(negedge clk);
      g = grant;
      step();
      req &= ~g;
    end
    check("mr_drain", 32'(req), 0);
    repeat (4) step();
    @(negedge clk);
    check("mr_busy_before", 32'(busy), 7);
    step();
    reset = 1'b0;
    #1;
    check("mr_busy", 32'(busy), 0);
    check("mr_done", 32'(done), 0);
    check("mr_tick", 32'(sec_tick), 0);
    check("mr_rem", 32'(remaining), 0);
    check("mr_grant", 32'(grant), 0);
    step();
    reset = 1'b1;
    step();
    // pointer back at ch0 and prescaler restarted from zero
    set_secs(0, 2);
    set_secs(3, 3);
    req = 4'b1001;
    @(negedge clk);
    check("post_grant0", 32'(grant), 1);
    step();
    req = 4'b1000;
    @(negedge clk);
    check("post_grant1", 32'(grant), 8);
    check("post_tick c1", 32'(sec_tick), 0);
    step();
    req = '0;
    for (int c = 2; c <= 10; c++) begin
      @(negedge clk);
      check($sformatf("post_tick c%0d", c), 32'(sec_tick), (c == 10) ? 1 : 0);
      step();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
